// File: rtl/boot_dump_controller.sv
// boot_dump_controller: copies a boot image from ROM into RAM and releases the CPU.
// On halt or watchdog expiry it settles, then streams a RAM window out over a valid/ready port.
module boot_dump_controller #(
    parameter int          ADDR_W      = 16,
    parameter int          DATA_W      = 8,
    parameter int          STAR_W      = 7,
    parameter int unsigned HALT_STATE  = 42,
    parameter int unsigned LOAD_BASE   = 0,
    parameter int unsigned LOAD_LEN    = 256,
    parameter int unsigned DUMP_BASE   = 0,
    parameter int unsigned DUMP_LEN    = 256,
    parameter int unsigned SETTLE      = 20,
    parameter int unsigned RUN_TIMEOUT = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              on,
    input  logic [STAR_W-1:0] star,
    output logic              cpu_reset,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              ram_rd,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    input  logic              dump_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_RUN, ST_SETTLE, ST_DUMP_RD, ST_DUMP_OUT, ST_DONE
    } state_t;

    state_t              r_state, w_next, w_post_run, w_post_settle;
    logic [31:0]         r_cnt, w_cnt_next;
    logic                r_timeout, w_timeout_next, r_fresh, w_halt;
    logic [DATA_W-1:0]   r_dump_data;

    assign w_halt        = star == STAR_W'(HALT_STATE);
    assign w_post_settle = (DUMP_LEN != 0) ? ST_DUMP_RD : ST_DONE;
    assign w_post_run    = (SETTLE != 0) ? ST_SETTLE : w_post_settle;

    // r_cnt is the LOAD pipeline index, RUN/SETTLE cycle count, or dump word index
    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt + 1;
        w_timeout_next = r_timeout;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next     = '0;
                w_timeout_next = 1'b0;
                if (on) w_next = (LOAD_LEN == 0) ? ST_RUN : ST_LOAD;
            end
            ST_LOAD: if (r_cnt == LOAD_LEN) begin
                w_next     = ST_RUN;
                w_cnt_next = '0;
            end
            ST_RUN: if (w_halt) begin
                w_next     = w_post_run;
                w_cnt_next = '0;
            end else if (RUN_TIMEOUT != 0 && r_cnt == RUN_TIMEOUT - 1) begin
                w_next         = w_post_run;
                w_cnt_next     = '0;
                w_timeout_next = 1'b1;
            end
            ST_SETTLE: if (r_cnt == SETTLE - 1) begin
                w_next     = w_post_settle;
                w_cnt_next = '0;
            end
            ST_DUMP_RD: begin
                w_next     = ST_DUMP_OUT;
                w_cnt_next = r_cnt;
            end
            ST_DUMP_OUT: begin
                w_cnt_next = r_cnt;
                if (dump_ready) begin
                    w_next     = (r_cnt == DUMP_LEN - 1) ? ST_DONE : ST_DUMP_RD;
                    w_cnt_next = r_cnt + 1;
                end
            end
            ST_DONE: w_cnt_next = r_cnt;
            default: w_next = ST_IDLE;
        endcase
        if (!on) begin
            w_next         = ST_IDLE;
            w_cnt_next     = '0;
            w_timeout_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_fresh     <= 1'b0;
            r_dump_data <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_timeout   <= w_timeout_next;
            r_fresh     <= r_state == ST_DUMP_RD && w_next == ST_DUMP_OUT;
            if (r_fresh) r_dump_data <= ram_rdata;
        end
    end

    // RAM read data is only valid in the first DUMP_OUT cycle; later cycles replay the latched copy
    assign src_rd     = r_state == ST_LOAD && r_cnt < LOAD_LEN;
    assign src_addr   = src_rd ? ADDR_W'(LOAD_BASE + r_cnt) : '0;
    assign ram_we     = r_state == ST_LOAD && r_cnt != 0;
    assign ram_rd     = r_state == ST_DUMP_RD;
    assign ram_addr   = ram_we ? ADDR_W'(LOAD_BASE + r_cnt - 1) :
                        ram_rd ? ADDR_W'(DUMP_BASE + r_cnt) : '0;
    assign ram_wdata  = ram_we ? src_data : '0;
    assign dump_valid = r_state == ST_DUMP_OUT;
    assign dump_data  = dump_valid ? (r_fresh ? ram_rdata : r_dump_data) : '0;
    assign dump_last  = dump_valid && r_cnt == DUMP_LEN - 1;
    assign cpu_reset  = r_state != ST_RUN;
    assign busy       = r_state != ST_IDLE && r_state != ST_DONE;
    assign done       = r_state == ST_DONE;
    assign timeout    = r_timeout;
endmodule
